fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the RISC-V core: owns the program counter, issues sequential word fetches to instruction memory over a valid/ready request channel, and buffers in-order responses in a DEPTH-entry queue that the decode stage drains via valid/ready. It replaces a hard-wired zero program counter with a configurable reset vector, configurable address width, configurable prefetch depth, a branch/jump redirect with flush of stale responses, and misaligned-target detection.

## Interface
- XLEN, 32: PC/address width (≥ 8).
- RESET_VECTOR, 0: PC loaded on reset; must be 4-byte aligned.
- DEPTH, 4: queue entries and maximum outstanding fetches; power of two, ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (equals internal fetch_pc).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response word valid; responses return in request order, latency ≥ 1 cycle, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  XLEN  new fetch target.
- inst_valid  out  1  head instruction available.
- inst_ready  in  1  decode consumes head.
- inst_data  out  32  head instruction word.
- inst_pc  out  XLEN  PC of head instruction.
- fetch_err  out  1  misaligned redirect target seen; held until cleared.

## Operation
- States: IDLE, FETCH, ERROR.
- IDLE: entered on reset; unconditional move to FETCH next cycle.
- FETCH: imem_req_valid = 1 when allocated entries < DEPTH and redirect_valid = 0. Request fires on valid && ready: fetch_pc's value is written into the PC field of the entry at alloc_ptr, alloc_ptr++, fetch_pc += 4 (mod 2^XLEN, wraps silently).
- Queue: three pointers, each with an extra wrap bit: head ≤ fill ≤ alloc. A response that is not dropped writes data to the fill entry and increments fill. inst_valid = (head != fill) && !redirect_valid. A consume fires on inst_valid && inst_ready and increments head.
- Redirect, any state: head = fill = alloc = 0, and drop_cnt = drop_cnt + (alloc − fill) + (number of responses outstanding and already being dropped). fetch_pc = redirect_pc.
  - If redirect_pc[1:0] != 0: go to ERROR and set fetch_err.
  - Otherwise: go to FETCH and clear fetch_err.
- Drop: while drop_cnt > 0, each imem_rsp_valid decrements drop_cnt and is discarded. drop_cnt is clog2(DEPTH)+2 bits wide and is bounded by 2·DEPTH.
- ERROR: imem_req_valid = 0. The queue stays empty. Responses are dropped per drop_cnt. Only a redirect leaves ERROR.
- Simultaneous events in the same cycle as redirect_valid:
  - A response is treated as stale: dropped and counted in the drop_cnt update.
  - Consumption is ignored.
  - No request is issued.
- Request and response in the same cycle: both take effect.
- Consume and response in the same cycle: both take effect.
- Full: alloc − head = DEPTH, so imem_req_valid = 0.
- Empty: head = fill, so inst_valid = 0. inst_data and inst_pc are don't-care.

## Timing
- Reset values: state IDLE, fetch_pc = RESET_VECTOR, all pointers 0, drop_cnt 0, imem_req_valid 0, inst_valid 0, fetch_err 0.
- Reset assertion clears all state immediately, mid-transaction included. Responses arriving later are not dropped; the memory side is reset together with this block.
- First request: imem_req_valid rises in the second cycle after reset deasserts, with imem_req_addr = RESET_VECTOR.
- Response to visibility: 1 cycle. A word on imem_rsp_valid at edge N drives inst_valid high after edge N.
- Redirect to new request: imem_req_valid = 1 with addr = redirect_pc in the cycle after the redirect pulse.
- Throughput: 1 request and 1 instruction per cycle sustained with single-cycle memory latency and DEPTH ≥ 2.
- imem_req_valid may drop without the request firing only on redirect, on full, or on entry to ERROR.

## Test plan
- Reset, RESET_VECTOR=0x100, memory always ready, latency 1, inst_ready=1 → requests 0x100, 0x104, 0x108…; inst_pc follows the same sequence one request per cycle; inst_data matches the memory image.
- inst_ready held 0, DEPTH=4 → exactly 4 requests fire (0x100–0x10C), then imem_req_valid = 0. Raising inst_ready → one new request per consumed entry.
- Latency 3, redirect_valid with redirect_pc=0x200 while 3 fetches are outstanding → the next 3 responses are discarded; the next inst_pc is 0x200 with the 0x200 word; no stale word is ever visible.
- redirect_pc=0x202 → fetch_err = 1, no requests issued. A later redirect to 0x300 → fetch_err = 0 and fetching resumes at 0x300.
- XLEN=8, redirect to 0xFC → fetch addresses 0xFC then 0x00 (wrap), with no error.
- Reset asserted mid-stream with a full queue → inst_valid and imem_req_valid go 0 immediately. After release, fetching restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the fetch PC, issues
// sequential word fetches, buffers in-order responses in a DEPTH-entry
// queue for decode, flushes on redirect and traps misaligned targets.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     DEPTH        = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_err
);

  localparam int unsigned AW = $clog2(DEPTH);  // entry index width
  localparam int unsigned PW = AW + 1;         // pointer width incl. wrap bit
  localparam int unsigned CW = AW + 2;         // drop counter width, holds 2*DEPTH

  typedef enum logic [1:0] {IDLE, FETCH, ERROR} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [PW-1:0]   r_head;   // next entry decode consumes
  logic [PW-1:0]   r_fill;   // next entry a response lands in
  logic [PW-1:0]   r_alloc;  // next entry a request claims
  logic [CW-1:0]   r_drop_cnt;

  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [31:0]     r_data_mem [DEPTH];

  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_keep;
  logic            w_consume;
  logic            w_misaligned;
  logic [PW-1:0]   w_used;
  logic [PW-1:0]   w_inflight;
  logic [CW-1:0]   w_drop_next;

  // Entries allocated but not yet consumed decide the full condition;
  // requests sent but not yet answered become stale on a redirect.
  assign w_used       = r_alloc - r_head;
  assign w_inflight   = r_alloc - r_fill;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  // A response in a redirect cycle is stale, as is any owed to an earlier flush.
  assign w_rsp_drop = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
  assign w_rsp_keep = imem_rsp_valid && !w_rsp_drop;

  // Stale total after a flush: already-doomed responses plus every unanswered
  // request, less the one being discarded in this very cycle.
  assign w_drop_next = r_drop_cnt + CW'(w_inflight) - CW'(imem_rsp_valid);

  assign inst_valid    = (r_head != r_fill) && !redirect_valid;
  assign w_consume     = inst_valid && inst_ready;
  assign w_req_fire    = imem_req_valid && imem_req_ready;
  assign imem_req_addr = r_fetch_pc;
  assign inst_data     = r_data_mem[r_head[AW-1:0]];
  assign inst_pc       = r_pc_mem[r_head[AW-1:0]];
  assign fetch_err     = (r_state == ERROR);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and request-valid decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    unique case (r_state)
      IDLE:    w_state_next = FETCH;
      FETCH:   imem_req_valid = (w_used != PW'(DEPTH)) && !redirect_valid;
      ERROR:   w_state_next = ERROR;
      default: w_state_next = IDLE;
    endcase
    if (redirect_valid) w_state_next = w_misaligned ? ERROR : FETCH;
  end

  // Fetch PC, queue pointers and stale-response counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_VECTOR;
      r_head     <= '0;
      r_fill     <= '0;
      r_alloc    <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_head     <= '0;
      r_fill     <= '0;
      r_alloc    <= '0;
      r_drop_cnt <= w_drop_next;
    end else begin
      if (w_req_fire) begin
        r_alloc    <= r_alloc + PW'(1);
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_rsp_keep) r_fill     <= r_fill + PW'(1);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_consume)  r_head     <= r_head + PW'(1);
    end
  end

  // Queue payload: PC captured at request, word captured at response.
  // NOTE: the payload arrays carry no reset; pointers alone decide which
  // entries are meaningful, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_pc_mem[r_alloc[AW-1:0]]  <= r_fetch_pc;
    if (w_rsp_keep) r_data_mem[r_fill[AW-1:0]] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with an in-order memory of variable
// latency, checks it cycle by cycle against a stream-level model
// (epoch-tagged requests, expected PC sequence, occupancy count), plus
// directed tables and sequences for the corner cases. A second instance
// with XLEN=8 covers address wrap.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance (XLEN=32)
  logic        req_valid, req_ready = 1'b0, rsp_valid = 1'b0, redirect = 1'b0;
  logic        inst_valid, inst_ready = 1'b0, fetch_err;
  logic [31:0] req_addr, rsp_data = '0, redirect_pc = '0, inst_data, inst_pc;

  // Small instance (XLEN=8), memory always ready with latency 1, decode always ready
  logic        s_req_valid, s_rsp_valid = 1'b0, s_redirect = 1'b0, s_inst_valid, s_fetch_err;
  logic        s_one = 1'b1;
  logic [7:0]  s_req_addr, s_redirect_pc = '0, s_inst_pc;
  logic [31:0] s_rsp_data = '0, s_inst_data;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .fetch_err(fetch_err)
  );

  fetch_unit #(.XLEN(8), .RESET_VECTOR(8'h00), .DEPTH(DEPTH)) u_small (
    .clk(clk), .reset(reset),
    .imem_req_valid(s_req_valid), .imem_req_addr(s_req_addr), .imem_req_ready(s_one),
    .imem_rsp_valid(s_rsp_valid), .imem_rsp_data(s_rsp_data),
    .redirect_valid(s_redirect), .redirect_pc(s_redirect_pc),
    .inst_valid(s_inst_valid), .inst_ready(s_one), .inst_data(s_inst_data),
    .inst_pc(s_inst_pc), .fetch_err(s_fetch_err)
  );

  // Memory image: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Memory environment
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  pend_t pend_q[$];
  int    cyc = 0, last_due = 0, epoch = 0, rsp_ep = -1;
  int    lat_min = 1, lat_max = 1, ready_pct = 100, iready_pct = 100, ir_force = -1;
  bit    redir_req = 1'b0;
  logic [31:0] redir_tgt = '0;

  // Small-instance environment
  bit         s_pend_v = 1'b0, s_redir_req = 1'b0, s_err_seen = 1'b0;
  logic [7:0] s_pend_a = '0, s_redir_tgt = '0;
  logic [7:0] s_fire_q[$], s_cons_q[$];
  logic [31:0] s_cons_d[$];

  // Reference model: stream position and counts, per spec rules
  logic [31:0] m_req_pc, m_inst_pc;
  int          m_occ, m_avail, m_idle;
  bit          m_err;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply inputs for the coming cycle.
  task automatic drive();
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend_q[0].addr);
      rsp_ep    = pend_q[0].epoch;
      pend_q.delete(0);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
      rsp_ep    = -1;
    end
    req_ready   = ($urandom_range(99) < ready_pct);
    inst_ready  = (ir_force >= 0) ? ir_force[0] : ($urandom_range(99) < iready_pct);
    redirect    = redir_req;
    redirect_pc = redir_tgt;
    s_rsp_valid   = s_pend_v;
    s_rsp_data    = mem_word({24'h0, s_pend_a});
    s_redirect    = s_redir_req;
    s_redirect_pc = s_redir_tgt;
  endtask

  // Compare settled outputs with the model, then advance model and memory.
  task automatic observe();
    bit e_rv, e_iv, fire_m, cons_m, live;
    int d;
    e_rv = (m_idle == 0) && !m_err && (m_occ < DEPTH) && !redirect;
    e_iv = (m_avail > 0) && !redirect;
    check("req_valid", req_valid, e_rv);
    check("inst_valid", inst_valid, e_iv);
    check("fetch_err", fetch_err, m_err);
    fire_m = e_rv && req_ready;
    cons_m = e_iv && inst_ready;
    if (fire_m) check("req_addr", req_addr, m_req_pc);
    if (e_iv) begin
      check("inst_pc", inst_pc, m_inst_pc);
      check("inst_data", inst_data, mem_word(m_inst_pc));
    end
    if (req_valid && req_ready) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_q.push_back('{req_addr, d, epoch});
    end
    live = rsp_valid && (rsp_ep == epoch) && !redirect;
    if (redirect) begin
      epoch++;
      m_occ     = 0;
      m_avail   = 0;
      m_req_pc  = redirect_pc;
      m_inst_pc = redirect_pc;
      m_err     = (redirect_pc[1:0] != 2'b00);
      m_idle    = 0;
    end else begin
      if (m_idle > 0) m_idle--;
      if (fire_m) begin m_occ++; m_req_pc += 4; end
      if (live) m_avail++;
      if (cons_m) begin m_occ--; m_avail--; m_inst_pc += 4; end
    end
    // Small instance bookkeeping
    if (s_redirect) begin
      s_fire_q.delete(); s_cons_q.delete(); s_cons_d.delete();
    end
    if (s_inst_valid && !s_redirect) begin
      s_cons_q.push_back(s_inst_pc);
      s_cons_d.push_back(s_inst_data);
    end
    s_pend_v = s_req_valid;
    s_pend_a = s_req_addr;
    if (s_req_valid) s_fire_q.push_back(s_req_addr);
    s_err_seen |= s_fetch_err;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    observe();
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, release, and run
  // the first (idle) cycle after release.
  task automatic do_reset(input int hold);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst inst_valid", inst_valid, 1'b0);
    check("rst req_valid", req_valid, 1'b0);
    check("rst fetch_err", fetch_err, 1'b0);
    repeat (hold) @(negedge clk);
    pend_q.delete();
    last_due  = cyc + 1;
    epoch++;
    m_req_pc  = RV;
    m_inst_pc = RV;
    m_occ     = 0;
    m_avail   = 0;
    m_err     = 1'b0;
    m_idle    = 1;
    s_pend_v  = 1'b0;
    redir_req = 1'b0;
    s_redir_req = 1'b0;
    reset = 1'b1;
    drive();
    #1;
    observe();
  endtask

  typedef struct {
    bit          ir;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    int n_c, n_r, waited;
    bit got;

    // Back-pressure table: decode stalled, DEPTH=4, latency 1, memory ready.
    vecs[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
    vecs[3]  = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h100};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
    vecs[7]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h104};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
    vecs[10] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h108};
    vecs[11] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h10C};
    vecs[12] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};
    vecs[13] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h114};

    // Phase 1: reset then the table.
    do_reset(2);
    for (int i = 0; i < 14; i++) begin
      ir_force = int'(vecs[i].ir);
      cycle();
      check($sformatf("tbl%0d req_valid", i), req_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) check($sformatf("tbl%0d req_addr", i), req_addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d inst_valid", i), inst_valid, vecs[i].exp_iv);
      if (vecs[i].exp_iv) check($sformatf("tbl%0d inst_pc", i), inst_pc, vecs[i].exp_pc);
    end

    // Phase 2: sustained throughput, one request and one instruction per cycle.
    ir_force = 1;
    n_c = 0; n_r = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (inst_valid && inst_ready) n_c++;
      if (req_valid && req_ready) n_r++;
    end
    check("throughput consumes", n_c, 20);
    check("throughput requests", n_r, 20);

    // Phase 3: latency 3, redirect with three fetches in flight.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    repeat (3) cycle();
    redir_req = 1'b1; redir_tgt = 32'h200;
    cycle();
    redir_req = 1'b0;
    cycle();
    check("redir next req_valid", req_valid, 1'b1);
    check("redir next req_addr", req_addr, 32'h200);
    got = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      cycle();
      waited++;
      if (inst_valid) got = 1'b1;
    end
    check("redir first inst seen", got, 1'b1);
    if (got) begin
      check("redir first inst_pc", inst_pc, 32'h200);
      check("redir first inst_data", inst_data, mem_word(32'h200));
    end
    repeat (4) cycle();

    // Phase 4: misaligned redirect traps, aligned redirect recovers.
    redir_req = 1'b1; redir_tgt = 32'h202;
    cycle();
    redir_req = 1'b0;
    n_r = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (req_valid) n_r++;
    end
    check("err fetch_err", fetch_err, 1'b1);
    check("err no requests", n_r, 0);
    redir_req = 1'b1; redir_tgt = 32'h300;
    cycle();
    redir_req = 1'b0;
    cycle();
    check("recover fetch_err", fetch_err, 1'b0);
    check("recover req_valid", req_valid, 1'b1);
    check("recover req_addr", req_addr, 32'h300);
    repeat (10) cycle();

    // Phase 5: XLEN=8 wrap from 0xFC to 0x00.
    s_err_seen = 1'b0;
    s_redir_req = 1'b1; s_redir_tgt = 8'hFC;
    cycle();
    s_redir_req = 1'b0;
    repeat (6) cycle();
    check("wrap fire count", s_fire_q.size() >= 3, 1'b1);
    check("wrap cons count", s_cons_q.size() >= 2, 1'b1);
    if (s_fire_q.size() >= 3) begin
      check("wrap req0", s_fire_q[0], 8'hFC);
      check("wrap req1", s_fire_q[1], 8'h00);
      check("wrap req2", s_fire_q[2], 8'h04);
    end
    if (s_cons_q.size() >= 2) begin
      check("wrap inst0 pc", s_cons_q[0], 8'hFC);
      check("wrap inst1 pc", s_cons_q[1], 8'h00);
      check("wrap inst0 data", s_cons_d[0], mem_word(32'hFC));
      check("wrap inst1 data", s_cons_d[1], mem_word(32'h00));
    end
    check("wrap no error", s_err_seen, 1'b0);

    // Phase 6: randomized traffic against the model.
    lat_min = 1; lat_max = 3; ready_pct = 70; iready_pct = 60; ir_force = -1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(19) == 0) begin
        tgt = 32'h1000 + ($urandom_range(255) << 2);
        if ($urandom_range(4) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
        redir_req = 1'b1;
        redir_tgt = tgt;
      end
      cycle();
      redir_req = 1'b0;
    end

    // Phase 7: fill the queue, then reset mid-stream.
    lat_min = 1; lat_max = 1; ready_pct = 100; ir_force = 0;
    redir_req = 1'b1; redir_tgt = 32'h400;
    cycle();
    redir_req = 1'b0;
    repeat (8) cycle();
    check("full inst_valid", inst_valid, 1'b1);
    check("full req_valid", req_valid, 1'b0);
    do_reset(1);
    ir_force = 1;
    cycle();
    check("restart req_valid", req_valid, 1'b1);
    check("restart req_addr", req_addr, RV);
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
